pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Run/halt sequencer and RAW-hazard stall controller for the 3-stage (IF/ID/EX) 16-bit CPU with a 4x16 register file.
- Gates PC and IF/ID loading.
- Injects bubbles into ID/EX.
- Tracks in-flight instruction validity.
- Supports start/stop/single-step plus a HALT opcode.
- Keeps retired-instruction and stall counters for debug.

Parameters:
HALT_OPCODE, 4'hF, opcode (instr[15:12]) treated as halt; bubbled, never executed.
CNT_W, 16, width of retired/stall counters.
START_RUNNING, 0, 1: reset state is RUN instead of HALTED.

Ports:
clock  in  1  system clock; all state updates on negedge clock (matches CPU pipeline).
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse: HALTED→RUN.
stop  in  1  one-cycle pulse: RUN→DRAIN.
step  in  1  one-cycle pulse: HALTED→STEP (execute exactly one instruction).
ifid_instr  in  16  IF/ID instruction register: rs=[11:10], rt=[9:8], opcode=[15:12].
id_ctrl  in  6  main_control output for ID instr: {RegDst, ALUSrc, RegWrite, ALUctl[2:0]}.
idex_regwrite  in  1  RegWrite currently in ID/EX.
idex_wreg  in  2  destination register of the instruction in EX.
fetch_en  out  1  load PC and IF/ID this cycle (comb).
idex_bubble  out  1  load zero control into ID/EX this cycle (comb).
halted  out  1  state==HALTED.
state  out  2  FSM state (HALTED=0, RUN=1, STEP=2, DRAIN=3).
retired_cnt  out  CNT_W  instructions completed in EX.
stall_cnt  out  CNT_W  hazard-stall cycles.

Behaviour:
- Internal regs: ifid_valid, idex_valid, state, counters. Reset (async, reset_n=0):
  - state=HALTED (RUN if START_RUNNING).
  - valids=0, counters=0.
  - Hence fetch_en=0, idex_bubble=1, halted=1 (0 if START_RUNNING).
  - Reset mid-run discards in-flight instructions immediately.
- Hazard (comb):
  - uses_rt = ~id_ctrl[4].
  - hit = idex_valid & idex_regwrite & ((idex_wreg==rs) | (uses_rt & idex_wreg==rt)).
  - stall = ifid_valid & hit.
- is_halt = ifid_valid & (ifid_instr[15:12]==HALTED_OPCODE).
- fetch_en = (state==RUN | state==STEP) & ~stall & ~is_halt.
- idex_bubble = ~ifid_valid | stall | is_halt.
- Next valids:
  - ifid_valid <= fetch_en ? 1 : (stall ? ifid_valid : 0).
  - idex_valid <= ~idex_bubble.
- Stall: PC/IF-ID held (fetch_en=0), one bubble per stall cycle. With a 3-stage pipe a stall lasts exactly 1 cycle.
- FSM:
  - HALTED:
    - start → RUN.
    - else step → STEP.
    - start & step together → RUN.
  - RUN: stop or is_halt → DRAIN.
  - STEP:
    - Exactly one fetch_en=1 cycle, then → DRAIN.
    - Pipeline is empty on entry, so no stall is possible.
  - DRAIN:
    - fetch_en=0. The IF/ID instruction (if valid, not HALT) still advances, stalling if needed.
    - → HALTED when ifid_valid==0 & idex_valid==0 at the cycle's start.
  - stop/start/step are ignored outside the states listed.
- HALT opcode: never enters EX (bubbled), not counted as retired. The instruction behind it is not fetched because fetch_en=0 that cycle.
- Counters, each wrapping at 2^CNT_W:
  - retired_cnt += 1 each cycle idex_valid=1.
  - stall_cnt += 1 each cycle stall=1.

Decomposition:
- Package pipe_ctrl_pkg:
  - State encodings.
  - Instruction field positions (opcode, rs, rt, rd).
  - id_ctrl bit indices: RegDst=5, ALUSrc=4, RegWrite=3.
  - Default HALT_OPCODE.
- One sub-module: pipe_hazard_detect (comb: ifid_instr, id_ctrl, idex_* → stall). It is reused later when forwarding is added.

Test Plan:
- Reset, then start: cycle 1 fetch_en=1, idex_bubble=1; cycle 2 idex_bubble=0; retired_cnt=1 after cycle 3; halted=0.
- RUN with idex_valid=1, idex_regwrite=1, idex_wreg=1, ifid_instr=16'h0600, id_ctrl ALUSrc=0 → stall one cycle: fetch_en=0, idex_bubble=1, stall_cnt=1; same with idex_wreg=2, ALUSrc=1 → no stall.
- ifid_instr=16'hF000 in RUN → fetch_en=0, idex_bubble=1; DRAIN then HALTED within 2 cycles; retired_cnt excludes HALT.
- stop pulse in RUN with valid IF/ID: that instruction retires (retired_cnt+1), no further fetch, halted=1 after pipeline empties.
- In HALTED, step pulse → exactly one fetch_en pulse, retired_cnt +1, back to HALTED; start & step together → RUN.
- reset_n low mid-RUN → immediately state=HALTED, fetch_en=0, counters=0, valids cleared; retired_cnt wrap: preload 16'hFFFF-path via long run → 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 3-stage (IF/ID/EX) CPU pipeline controller:
//   - run/halt sequencer state encoding
//   - instruction field positions (opcode, rs, rt, rd)
//   - main_control (id_ctrl) bit indices
//   - default HALT opcode
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Encoding is visible on the 'state' debug port, so values are fixed.
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;

  // id_ctrl = {RegDst, ALUSrc, RegWrite, ALUctl[2:0]}
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGWRITE = 3;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  function automatic logic [3:0] instr_opcode(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [15:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [1:0] instr_rt(input logic [15:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [15:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_detect
// Combinational RAW-hazard detector between the instruction in IF/ID (being
// decoded) and the instruction in ID/EX (about to write back).
// Ports:
//   ifid_valid     in   IF/ID holds a real instruction
//   ifid_instr     in   IF/ID instruction word
//   id_ctrl        in   main_control output for the ID instruction
//   idex_valid     in   ID/EX holds a real instruction
//   idex_regwrite  in   RegWrite of the ID/EX instruction
//   idex_wreg      in   destination register of the ID/EX instruction
//   stall          out  hold IF/ID and bubble ID/EX this cycle
// -----------------------------------------------------------------------------
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic        ifid_valid,
  input  logic [15:0] ifid_instr,
  input  logic [5:0]  id_ctrl,
  input  logic        idex_valid,
  input  logic        idex_regwrite,
  input  logic [1:0]  idex_wreg,
  output logic        stall
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;
  logic raw_hit;

  // With ALUSrc set the second operand is the immediate, so rt is not read.
  assign uses_rt  = ~id_ctrl[CTRL_ALUSRC];
  assign rs_match = (idex_wreg == instr_rs(ifid_instr));
  assign rt_match = uses_rt & (idex_wreg == instr_rt(ifid_instr));
  assign raw_hit  = idex_valid & idex_regwrite & (rs_match | rt_match);
  assign stall    = ifid_valid & raw_hit;

  // Fields not needed for hazard detection (kept on the port for reuse when
  // forwarding is added).
  logic unused_ok;
  assign unused_ok = ^{ifid_instr[OPC_MSB:OPC_LSB], ifid_instr[7:0],
                       id_ctrl[CTRL_REGDST], id_ctrl[CTRL_REGWRITE],
                       id_ctrl[2:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Run/halt sequencer and RAW-hazard stall controller for the 3-stage
// (IF/ID/EX) 16-bit CPU. All state changes on the falling clock edge to match
// the CPU pipeline registers.
// Ports:
//   clock          in   system clock (state updates on negedge)
//   reset_n        in   asynchronous active-low reset
//   start          in   pulse: HALTED -> RUN
//   stop           in   pulse: RUN -> DRAIN
//   step           in   pulse: HALTED -> STEP (execute one instruction)
//   ifid_instr     in   IF/ID instruction register
//   id_ctrl        in   main_control output for the ID instruction
//   idex_regwrite  in   RegWrite currently in ID/EX
//   idex_wreg      in   destination register of the EX instruction
//   fetch_en       out  load PC and IF/ID this cycle
//   idex_bubble    out  load zero control into ID/EX this cycle
//   halted         out  sequencer is HALTED
//   state          out  sequencer state (HALTED=0 RUN=1 STEP=2 DRAIN=3)
//   retired_cnt    out  instructions completed in EX (wrapping)
//   stall_cnt      out  hazard-stall cycles (wrapping)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE   = DEFAULT_HALT_OPCODE,
  parameter int         CNT_W         = 16,
  parameter bit         START_RUNNING = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [15:0]      ifid_instr,
  input  logic [5:0]       id_ctrl,
  input  logic             idex_regwrite,
  input  logic [1:0]       idex_wreg,
  output logic             fetch_en,
  output logic             idex_bubble,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam state_t RST_STATE = START_RUNNING ? ST_RUN : ST_HALTED;

  state_t           state_q, state_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             idex_valid_q, idex_valid_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic stall;
  logic is_halt;

  pipe_hazard_detect u_hazard (
    .ifid_valid    (ifid_valid_q),
    .ifid_instr    (ifid_instr),
    .id_ctrl       (id_ctrl),
    .idex_valid    (idex_valid_q),
    .idex_regwrite (idex_regwrite),
    .idex_wreg     (idex_wreg),
    .stall         (stall)
  );

  // A HALT in IF/ID is never passed to EX and blocks the fetch behind it.
  assign is_halt = ifid_valid_q & (instr_opcode(ifid_instr) == HALT_OPCODE);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives state_d; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_HALTED: begin
        // start wins when start and step arrive together
        if (start)     state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (stop || is_halt) state_d = ST_DRAIN;
      end
      ST_STEP: begin
        // Entered with an empty pipe, so the single fetch happens on the
        // first STEP cycle.
        if (fetch_en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave only once nothing is left in flight at the start of the cycle.
        if (!ifid_valid_q && !idex_valid_q) state_d = ST_HALTED;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_en    = 1'b0;
    idex_bubble = 1'b1;
    halted      = 1'b0;
    fetch_en    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stall && !is_halt;
    idex_bubble = !ifid_valid_q || stall || is_halt;
    halted      = (state_q == ST_HALTED);
  end

  assign state       = state_q;
  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  // ---------------------------------------------------------------------------
  // In-flight validity and debug counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // IF/ID is refilled on fetch, held on a stall, emptied otherwise
    // (DRAIN/STEP advance or a discarded HALT).
    ifid_valid_d  = fetch_en | (stall & ifid_valid_q);
    idex_valid_d  = ~idex_bubble;
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, idex_valid_q};
    stall_cnt_d   = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ifid_valid_q  <= 1'b0;
      idex_valid_q  <= 1'b0;
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ifid_valid_q  <= ifid_valid_d;
      idex_valid_q  <= idex_valid_d;
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: directed scenarios with hand-derived
// values, then randomized traffic against a behavioural model of the
// sequencer and pipeline occupancy, then a long run for counter wrap.
// Inputs change on posedge; the DUT updates on negedge; outputs are sampled
// 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int M_HALTED = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, stop, step;
  logic [15:0] ifid_instr;
  logic [5:0]  id_ctrl;
  logic        idex_regwrite;
  logic [1:0]  idex_wreg;
  logic        fetch_en, idex_bubble, halted;
  logic [1:0]  state;
  logic [15:0] retired_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .HALT_OPCODE   (4'hF),
    .CNT_W         (16),
    .START_RUNNING (1'b0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .step          (step),
    .ifid_instr    (ifid_instr),
    .id_ctrl       (id_ctrl),
    .idex_regwrite (idex_regwrite),
    .idex_wreg     (idex_wreg),
    .fetch_en      (fetch_en),
    .idex_bubble   (idex_bubble),
    .halted        (halted),
    .state         (state),
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;
  bit          m_if, m_ex;
  int unsigned m_retired, m_stalls;
  bit          e_fetch, e_bubble, e_stall, e_halt;

  task automatic model_reset();
    m_mode    = M_HALTED;
    m_if      = 1'b0;
    m_ex      = 1'b0;
    m_retired = 0;
    m_stalls  = 0;
  endtask

  // Expected combinational behaviour from the current inputs and occupancy.
  task automatic model_eval();
    bit [1:0] rs, rt;
    bit       reads_rt, conflict;
    rs       = ifid_instr[11:10];
    rt       = ifid_instr[9:8];
    reads_rt = !id_ctrl[4];
    conflict = m_ex && idex_regwrite && (idex_wreg == rs || (reads_rt && idex_wreg == rt));
    e_stall  = m_if && conflict;
    e_halt   = m_if && (ifid_instr[15:12] == 4'hF);
    e_fetch  = (m_mode == M_RUN || m_mode == M_STEP) && !e_stall && !e_halt;
    e_bubble = !m_if || e_stall || e_halt;
  endtask

  task automatic model_advance();
    m_retired += m_ex;
    m_stalls  += e_stall;
    case (m_mode)
      M_HALTED: if (start) m_mode = M_RUN; else if (step) m_mode = M_STEP;
      M_RUN:    if (stop || e_halt) m_mode = M_DRAIN;
      M_STEP:   if (e_fetch) m_mode = M_DRAIN;
      default:  if (!m_if && !m_ex) m_mode = M_HALTED;
    endcase
    m_if = e_fetch || e_stall;
    m_ex = !e_bubble;
  endtask

  // One clock cycle: drive, sample, compare against model, advance model.
  task automatic tick(input bit s_start, input bit s_stop, input bit s_step,
                      input logic [15:0] instr, input logic [5:0] ctrl,
                      input bit rw, input logic [1:0] wreg);
    @(posedge clock);
    start         = s_start;
    stop          = s_stop;
    step          = s_step;
    ifid_instr    = instr;
    id_ctrl       = ctrl;
    idex_regwrite = rw;
    idex_wreg     = wreg;
    #1;
    model_eval();
    check("fetch_en",    fetch_en,    e_fetch);
    check("idex_bubble", idex_bubble, e_bubble);
    check("state",       state,       m_mode);
    check("halted",      halted,      m_mode == M_HALTED);
    check("retired_cnt", retired_cnt, m_retired & 32'hFFFF);
    check("stall_cnt",   stall_cnt,   m_stalls & 32'hFFFF);
    model_advance();
  endtask

  task automatic nop_tick();
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    @(posedge clock);
    start = 1'b0; stop = 1'b0; step = 1'b0; idex_regwrite = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_state",   state,       0);
    check("rst_halted",  halted,      1);
    check("rst_fetch",   fetch_en,    0);
    check("rst_bubble",  idex_bubble, 1);
    check("rst_retired", retired_cnt, 0);
    check("rst_stalls",  stall_cnt,   0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int nf;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    ifid_instr = 16'h0000; id_ctrl = 6'h00; idex_regwrite = 1'b0; idex_wreg = 2'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_state",   state,       0);
    check("reset_halted",  halted,      1);
    check("reset_fetch",   fetch_en,    0);
    check("reset_bubble",  idex_bubble, 1);
    check("reset_retired", retired_cnt, 0);
    check("reset_stalls",  stall_cnt,   0);
    reset_n = 1'b1;

    // ---- start and pipeline fill ----
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
    nop_tick();
    check("fill_c1_fetch",  fetch_en,    1);
    check("fill_c1_bubble", idex_bubble, 1);
    nop_tick();
    check("fill_c2_bubble", idex_bubble, 0);
    nop_tick();
    nop_tick();
    check("fill_retired", retired_cnt, 1);
    check("fill_halted",  halted,      0);

    // ---- RAW hazard on rs, then rt ignored with ALUSrc ----
    tick(1'b0, 1'b0, 1'b0, 16'h0600, 6'b000000, 1'b1, 2'd1);
    check("hz_fetch",  fetch_en,    0);
    check("hz_bubble", idex_bubble, 1);
    nop_tick();
    check("hz_stall_cnt", stall_cnt, 1);
    check("hz_refetch",   fetch_en,  1);
    tick(1'b0, 1'b0, 1'b0, 16'h0600, 6'b010000, 1'b1, 2'd2);
    check("nohz_fetch",  fetch_en,    1);
    check("nohz_bubble", idex_bubble, 0);
    nop_tick();
    check("nohz_stall_cnt", stall_cnt, 1);

    // ---- HALT opcode ----
    tick(1'b0, 1'b0, 1'b0, 16'hF000, 6'h00, 1'b0, 2'd0);
    check("halt_fetch",  fetch_en,    0);
    check("halt_bubble", idex_bubble, 1);
    nop_tick();
    check("halt_drain", state, 3);
    nop_tick();
    check("halt_halted",  halted,      1);
    check("halt_retired", retired_cnt, 6);
    nop_tick();
    check("halt_retired_hold", retired_cnt, 6);

    // ---- stop pulse with a valid IF/ID ----
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
    repeat (3) nop_tick();
    tick(1'b0, 1'b1, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
    check("stop_cycle_fetch", fetch_en, 1);
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      nop_tick();
      nf += int'(fetch_en);
    end
    check("stop_no_fetch", nf, 0);
    check("stop_halted",   halted, 1);
    check("stop_retired",  retired_cnt, 10);

    // ---- single step ----
    tick(1'b0, 1'b0, 1'b1, 16'h0000, 6'h00, 1'b0, 2'd0);
    nop_tick();
    check("step_state", state, 2);
    nf = int'(fetch_en);
    for (int i = 0; i < 5; i++) begin
      nop_tick();
      nf += int'(fetch_en);
    end
    check("step_one_fetch", nf, 1);
    check("step_halted",    halted, 1);
    check("step_retired",   retired_cnt, 11);

    // ---- start and step together ----
    tick(1'b1, 1'b0, 1'b1, 16'h0000, 6'h00, 1'b0, 2'd0);
    nop_tick();
    check("start_step_run", state, 1);
    repeat (3) nop_tick();

    // ---- reset mid-run ----
    mid_reset();
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
    nop_tick();
    check("post_rst_bubble", idex_bubble, 1);

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, 16'($urandom), 6'($urandom_range(0, 63)),
           1'($urandom), 2'($urandom));
    end

    // ---- retired counter wrap ----
    mid_reset();
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 2'd0);
    for (int i = 0; i < 70000 && m_retired < 65536; i++) nop_tick();
    nop_tick();
    check("wrap_retired", retired_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
